// File: rtl/hash160_ctrl.sv
// Hash160 sequencer: one padded SHA-256 block in, RIPEMD-160 of the digest out.
// Ports: clk/rst, host i_valid/i_ready/i_block, SHA core sha_start/sha_block/
//   sha_done/sha_digest, RIPEMD core rmd_start/rmd_block/rmd_done/rmd_ans,
//   result o_valid/o_hash, timeout pulse o_err, busy.
module hash160_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         i_ready,
   input  logic [511:0] i_block,
   output logic         sha_start,
   output logic [511:0] sha_block,
   input  logic         sha_done,
   input  logic [255:0] sha_digest,
   output logic         rmd_start,
   output logic [511:0] rmd_block,
   input  logic         rmd_done,
   input  logic [159:0] rmd_ans,
   output logic         o_valid,
   output logic [159:0] o_hash,
   output logic         o_err,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE, SHA_GO, SHA_WAIT, RMD_GO, RMD_WAIT, DONE, ERR
   } state_t;

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t        state;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         i_ready   <= 1'b1;
         busy      <= 1'b0;
         sha_start <= 1'b0;
         rmd_start <= 1'b0;
         o_valid   <= 1'b0;
         o_err     <= 1'b0;
         o_hash    <= '0;
         sha_block <= '0;
         rmd_block <= '0;
         cnt       <= '0;
      end else begin
         // all pulse outputs default low; a state raises one for one cycle
         sha_start <= 1'b0;
         rmd_start <= 1'b0;
         o_valid   <= 1'b0;
         o_err     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  sha_block <= i_block;
                  i_ready   <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SHA_GO;
               end
            end
            SHA_GO: begin
               sha_start <= 1'b1;
               cnt       <= '0;
               state     <= SHA_WAIT;
            end
            SHA_WAIT: begin
               // done is checked before the timeout so a tie completes
               if (sha_done) begin
                  // digest, 0x80 marker, LE bit length 256 in bytes 56..63
                  rmd_block <= {sha_digest, 8'h80, 184'h0,
                                8'h00, 8'h01, 48'h0};
                  state     <= RMD_GO;
               end else if (cnt == TMO) begin
                  o_err <= 1'b1;
                  state <= ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RMD_GO: begin
               rmd_start <= 1'b1;
               cnt       <= '0;
               state     <= RMD_WAIT;
            end
            RMD_WAIT: begin
               if (rmd_done) begin
                  o_hash  <= rmd_ans;
                  o_valid <= 1'b1;
                  state   <= DONE;
               end else if (cnt == TMO) begin
                  o_err <= 1'b1;
                  state <= ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE, ERR: begin
               i_ready <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: begin
               i_ready <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
